// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helpers for the PWM peripheral, the SPI register file
// and the top-level wrapper.
//   PWM_CNT_W       : PWM counter / duty register width
//   DUTY_FULL       : duty code meaning "always high"
//   NUM_PINS        : number of driven output pins
//   DEFAULT_CLK_DIV : default prescaler divide ratio
//   pin_mode_e      : per-pin drive mode
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned            PWM_CNT_W       = 8;
    localparam logic [PWM_CNT_W-1:0]   DUTY_FULL       = 8'hFF;
    localparam int unsigned            NUM_PINS        = 16;
    localparam int unsigned            DEFAULT_CLK_DIV = 13;

    typedef enum logic [1:0] {
        PIN_LOW  = 2'd0,
        PIN_HIGH = 2'd1,
        PIN_PWM  = 2'd2
    } pin_mode_e;

    // Output enable dominates; PWM select only matters for enabled pins.
    function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return PIN_LOW;
        end else if (!en_pwm) begin
            return PIN_HIGH;
        end
        return PIN_PWM;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus PWM count generator. One PWM count lasts CLK_DIV clocks; a
// period is 2**CNT_W counts.
//   i_clk          : system clock
//   i_rst          : synchronous active-high reset
//   o_cnt          : current PWM count
//   o_wrap         : high on the last clock of a period (count about to wrap)
//   o_period_start : one-clock pulse on the first clock of each period
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CNT_W   = PWM_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_period_start
);

    // CLK_DIV = 1 still needs a 1-bit prescaler; it simply stays at 0.
    localparam int unsigned      PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_DIV - 1);

    logic [PS_W-1:0]  r_prescaler;
    logic [CNT_W-1:0] r_pwm_cnt;
    logic             r_period_start;
    logic             w_tick;
    logic             w_wrap;

    assign w_tick = (r_prescaler == PS_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescaler    <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_prescaler <= '0;
                r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
            // Registered so the pulse lands on the clock where the count is 0.
            r_period_start <= w_wrap;
        end
    end

    assign o_cnt          = r_pwm_cnt;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Drives 16 pins as forced-low, static-high or a shared PWM waveform, from
// configuration bytes written by the SPI register file. Duty is
// double-buffered and only takes effect at a period boundary.
//   clk              : system clock
//   rst              : synchronous active-high reset
//   en_reg_out_7_0   : output enable, pins 7..0
//   en_reg_out_15_8  : output enable, pins 15..8
//   en_reg_pwm_7_0   : PWM mode select, pins 7..0
//   en_reg_pwm_15_8  : PWM mode select, pins 15..8
//   pwm_duty_cycle   : requested duty (0x00 = 0%, 0xFF = 100%)
//   pwm_out          : pin drive, [7:0] -> uo_out, [15:8] -> uio_out
//   period_start     : one-clock pulse on the first clock of each period
// -----------------------------------------------------------------------------
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CNT_W   = PWM_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [CNT_W-1:0]    pwm_duty_cycle,
    output logic [NUM_PINS-1:0] pwm_out,
    output logic                period_start
);

    logic [NUM_PINS-1:0] r_en_out;
    logic [NUM_PINS-1:0] r_en_pwm;
    logic [CNT_W-1:0]    r_duty;
    logic [CNT_W-1:0]    r_duty_shadow;
    logic [NUM_PINS-1:0] r_pwm_out;

    logic [CNT_W-1:0]    w_cnt;
    logic                w_wrap;
    logic                w_pwm_sig;
    logic [NUM_PINS-1:0] w_pin_next;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_timebase (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_cnt          (w_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (period_start)
    );

    // Capture stage isolates the SPI register fan-out; the shadow duty only
    // updates on wrap so a mid-period write cannot glitch the waveform.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_out      <= '0;
            r_en_pwm      <= '0;
            r_duty        <= '0;
            r_duty_shadow <= '0;
        end else begin
            r_en_out <= {en_reg_out_15_8, en_reg_out_7_0};
            r_en_pwm <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
            r_duty   <= pwm_duty_cycle;
            if (w_wrap) begin
                r_duty_shadow <= r_duty;
            end
        end
    end

    // Full-scale duty is special-cased so the last count does not drop low.
    always_comb begin
        w_pwm_sig = 1'b0;
        if (r_duty_shadow == DUTY_FULL) begin
            w_pwm_sig = 1'b1;
        end else begin
            w_pwm_sig = (w_cnt < r_duty_shadow);
        end
    end

    always_comb begin
        w_pin_next = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            case (pin_mode(r_en_out[i], r_en_pwm[i]))
                PIN_HIGH: w_pin_next[i] = 1'b1;
                PIN_PWM:  w_pin_next[i] = w_pwm_sig;
                default:  w_pin_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_out <= '0;
        end else begin
            r_pwm_out <= w_pin_next;
        end
    end

    assign pwm_out = r_pwm_out;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Self-checking bench for pwm_peripheral with CLK_DIV = 13 (period 3328 clks).
// A reference model derives counts from elapsed clocks since reset.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int unsigned CLK_DIV = 13;
    localparam int unsigned PERIOD  = CLK_DIV * 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
    logic [15:0] pwm_out;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    // ---------------- reference model ----------------
    // m_t counts clocks seen since reset; the PWM count and period boundaries
    // follow from plain division of that number.
    int unsigned m_t = 0;
    logic [15:0] m_cap_out = '0, m_cap_pwm = '0;
    logic [7:0]  m_cap_duty = '0, m_shadow = '0;
    logic [15:0] exp_out = '0;
    logic        exp_ps = 1'b0;
    logic        m_lvl;

    function automatic logic ref_level(input int unsigned t, input logic [7:0] d);
        int unsigned cnt;
        cnt = (t / CLK_DIV) % 256;
        if (d == 8'hFF) return 1'b1;
        return (cnt < 32'(d));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_cap_out = '0; m_cap_pwm = '0; m_cap_duty = '0;
            m_shadow = '0; exp_out = '0; exp_ps = 1'b0;
        end else begin
            m_lvl   = ref_level(m_t, m_shadow);
            exp_out = m_cap_out & (~m_cap_pwm | {16{m_lvl}});
            m_t     = m_t + 1;
            exp_ps  = ((m_t % PERIOD) == 0);
            if (exp_ps) m_shadow = m_cap_duty;
            m_cap_out  = {eo_hi, eo_lo};
            m_cap_pwm  = {ep_hi, ep_lo};
            m_cap_duty = duty;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_cfg(input logic [15:0] en_o, input logic [15:0] en_p, input logic [7:0] d);
        {eo_hi, eo_lo} = en_o;
        {ep_hi, ep_lo} = en_p;
        duty = d;
    endtask

    task automatic wait_ps(output bit found, output int n);
        found = 1'b0;
        n = 0;
        while (n < 4000 && !found) begin
            @(negedge clk);
            n++;
            if (period_start === 1'b1) found = 1'b1;
        end
    endtask

    // Samples one full period: high count on pin 0, index of first
    // period_start, samples where pins disagree, samples off the model.
    task automatic measure(output int high, output int ps_at, output int split, output int model_bad);
        high = 0; ps_at = 0; split = 0; model_bad = 0;
        for (int i = 1; i <= int'(PERIOD); i++) begin
            @(negedge clk);
            if (pwm_out[0] === 1'b1) high++;
            if (pwm_out !== 16'h0000 && pwm_out !== 16'hFFFF) split++;
            if (period_start === 1'b1 && ps_at == 0) ps_at = i;
            if (pwm_out !== exp_out || period_start !== exp_ps) model_bad++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int high, ps_at, split, bad;
        rst = 1'b1;
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== 16'h0000) begin
                errors++; $display("FAIL reset_pwm_out: got %h expected 0000", pwm_out);
            end
            checks++;
            if (period_start !== 1'b0) begin
                errors++; $display("FAIL reset_period_start: got %b expected 0", period_start);
            end
        end
        rst = 1'b0;
        measure(high, ps_at, split, bad);
        checks++;
        if (ps_at != int'(PERIOD)) begin
            errors++; $display("FAIL reset_first_period_start: got %0d expected %0d", ps_at, PERIOD);
        end
        checks++;
        if (high != 0) begin
            errors++; $display("FAIL reset_first_period_low: got %0d expected 0", high);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_model: got %0d expected 0", bad);
        end
    endtask

    task automatic test_static();
        bit found;
        int n;
        int bad;
        set_cfg(16'h00FF, 16'h0000, 8'h00);
        @(negedge clk);
        checks++;
        if (pwm_out !== exp_out) begin
            errors++; $display("FAIL static_latency1: got %h expected %h", pwm_out, exp_out);
        end
        @(negedge clk);
        checks++;
        if (pwm_out !== 16'h00FF) begin
            errors++; $display("FAIL static_latency2: got %h expected 00ff", pwm_out);
        end
        set_cfg(16'hFFFF, 16'hFF00, 8'h00);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL static_wait_ps: got timeout expected period_start");
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm_out !== 16'h00FF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL static_steady: got %0d bad samples expected 0", bad);
        end
    endtask

    task automatic test_duty_50();
        bit found;
        int n, high, ps_at, split, bad;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL duty50_wait_ps: got timeout expected period_start");
        end
        measure(high, ps_at, split, bad);
        checks++;
        if (high != 1664) begin
            errors++; $display("FAIL duty50_high: got %0d expected 1664", high);
        end
        checks++;
        if (ps_at != int'(PERIOD)) begin
            errors++; $display("FAIL duty50_period: got %0d expected %0d", ps_at, PERIOD);
        end
        checks++;
        if (split != 0) begin
            errors++; $display("FAIL duty50_aligned: got %0d split samples expected 0", split);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL duty50_model: got %0d expected 0", bad);
        end
    endtask

    task automatic test_extremes();
        bit found;
        int n, high, ps_at, split, bad;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL duty0_wait_ps: got timeout expected period_start");
        end
        measure(high, ps_at, split, bad);
        checks++;
        if (high != 0 || split != 0) begin
            errors++; $display("FAIL duty0_high: got %0d (split %0d) expected 0", high, split);
        end
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL duty100_wait_ps: got timeout expected period_start");
        end
        measure(high, ps_at, split, bad);
        checks++;
        if (high != int'(PERIOD) || split != 0) begin
            errors++; $display("FAIL duty100_high: got %0d (split %0d) expected %0d", high, split, PERIOD);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL extremes_model: got %0d expected 0", bad);
        end
    endtask

    task automatic test_double_buffer();
        bit found;
        int n, high, ps_at, split, bad;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL dbuf_wait_ps: got timeout expected period_start");
        end
        high = 0;
        ps_at = 0;
        for (int i = 1; i <= int'(PERIOD); i++) begin
            @(negedge clk);
            if (pwm_out[0] === 1'b1) high++;
            if (period_start === 1'b1 && ps_at == 0) ps_at = i;
            if (i == 1600) duty = 8'hC0;
        end
        checks++;
        if (high != 832) begin
            errors++; $display("FAIL dbuf_current_high: got %0d expected 832", high);
        end
        checks++;
        if (ps_at != int'(PERIOD)) begin
            errors++; $display("FAIL dbuf_boundary: got %0d expected %0d", ps_at, PERIOD);
        end
        measure(high, ps_at, split, bad);
        checks++;
        if (high != 2496) begin
            errors++; $display("FAIL dbuf_next_high: got %0d expected 2496", high);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL dbuf_model: got %0d expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int n, high, ps_at, split, bad;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(found, n);
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_wait_ps: got timeout expected period_start");
        end
        n = 0;
        while (((m_t / CLK_DIV) % 256) != 32'h30 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++; $display("FAIL rstmid_reach_cnt: got timeout expected count 0x30");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: got %h/%b expected 0000/0", pwm_out, period_start);
        end
        rst = 1'b0;
        measure(high, ps_at, split, bad);
        checks++;
        if (high != 0 || ps_at != int'(PERIOD)) begin
            errors++; $display("FAIL rstmid_first_period: got high %0d ps %0d expected 0/%0d", high, ps_at, PERIOD);
        end
        measure(high, ps_at, split, bad);
        checks++;
        if (high != 1664) begin
            errors++; $display("FAIL rstmid_second_high: got %0d expected 1664", high);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rstmid_model: got %0d expected 0", bad);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== exp_out || period_start !== exp_ps) begin
                errors++;
                if (shown < 10) begin
                    $display("FAIL random_cycle%0d: got %h/%b expected %h/%b", i, pwm_out, period_start, exp_out, exp_ps);
                end
                shown++;
            end
            if ($urandom_range(199, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: duty = 8'h00;
                    1: duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
                {eo_hi, eo_lo} = 16'($urandom);
                {ep_hi, ep_lo} = 16'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_duty_50();
        test_extremes();
        test_double_buffer();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
